// File: rtl/dma16_if.sv
// Signal bundle for dma16: CPU register window, hold/busy bus grant and the shared memory bus.
// master = engine side, slave = system side (CPU decode, bus mux, memory).
interface dma16_if;
  logic        cfg_sel;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_din;
  logic        cfg_we;
  logic [15:0] cfg_dout;
  logic        hold;
  logic        busy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [15:0] dma_din;
  logic [15:0] dma_dout;
  logic        dma_we;
  logic        irq;

  modport master (
    input  cfg_sel, cfg_addr, cfg_din, cfg_we, busy, dma_din,
    output cfg_dout, hold, dma_active, dma_addr, dma_dout, dma_we, irq
  );

  modport slave (
    output cfg_sel, cfg_addr, cfg_din, cfg_we, busy, dma_din,
    input  cfg_dout, hold, dma_active, dma_addr, dma_dout, dma_we, irq
  );
endinterface

// File: rtl/dma16.sv
// dma16: block-copy engine; 3 cycles/word (1 in fill mode, built only with `DMA_FILL_EN), cfg_dout 1-cycle read.
// Backpressure: stalls in REQ while busy=1; once granted the bus is kept until the last word is written.
module dma16 (
  input  logic    clk,
  input  logic    reset_n,
  dma16_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_READ, S_CAPTURE, S_WRITE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_q, dst_q, len_q;
  logic [15:0] dout_q, cfg_dout_q, rd_dat;
  logic        done_q, irq_q;
  logic        run, cfg_wr, ctrl_wr, start, start_go, start_zero, last_word;
  logic        fill_q, fill_start;
  logic        hold, active, we;
  logic [15:0] addr;

  assign run        = (state_q != S_IDLE);
  assign cfg_wr     = bus.cfg_sel & bus.cfg_we & ~run;
  assign ctrl_wr    = cfg_wr & (bus.cfg_addr == 2'd3);
  assign start      = ctrl_wr & bus.cfg_din[0];
  assign start_go   = start & (len_q != 16'd0);
  assign start_zero = start & (len_q == 16'd0);
  assign last_word  = (len_q == 16'd1);

`ifdef DMA_FILL_EN
  // Fill pattern is SRC itself, frozen into the write-data register at start.
  assign fill_start = start_go & bus.cfg_din[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q <= 1'b0;
    end else if (ctrl_wr) begin
      fill_q <= bus.cfg_din[1];
    end
  end
`else
  assign fill_start = 1'b0;
  assign fill_q     = 1'b0;
`endif

  // Bus outputs decode straight from state so reset removes them without waiting for a clock.
  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    active  = 1'b0;
    we      = 1'b0;
    addr    = 16'd0;
    case (state_q)
      S_IDLE: begin
        if (start_go) state_d = S_REQ;
      end
      S_REQ: begin
        hold = 1'b1;
        if (!bus.busy) state_d = fill_q ? S_WRITE : S_READ;
      end
      S_READ: begin
        hold    = 1'b1;
        active  = 1'b1;
        addr    = src_q;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        hold    = 1'b1;
        active  = 1'b1;
        addr    = src_q;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        hold   = 1'b1;
        active = 1'b1;
        we     = 1'b1;
        addr   = dst_q;
        if (last_word)   state_d = S_DONE;
        else if (fill_q) state_d = S_WRITE;
        else             state_d = S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_dat = 16'd0;
    case (bus.cfg_addr)
      2'd0:    rd_dat = src_q;
      2'd1:    rd_dat = dst_q;
      2'd2:    rd_dat = len_q;
      default: rd_dat = {13'd0, fill_q, done_q, run};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_q      <= 16'd0;
      dst_q      <= 16'd0;
      len_q      <= 16'd0;
      dout_q     <= 16'd0;
      cfg_dout_q <= 16'd0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= (state_d == S_DONE) | start_zero;

      if (cfg_wr) begin
        case (bus.cfg_addr)
          2'd0:    src_q  <= bus.cfg_din;
          2'd1:    dst_q  <= bus.cfg_din;
          2'd2:    len_q  <= bus.cfg_din;
          default: done_q <= start_zero;
        endcase
      end

      // cfg_wr is blocked while running, so this never collides with the CTRL clear above.
      if (state_q == S_DONE) done_q <= 1'b1;

      if (state_q == S_CAPTURE) dout_q <= bus.dma_din;
      if (fill_start)           dout_q <= src_q;

      if (state_q == S_WRITE) begin
        if (!fill_q) src_q <= src_q + 16'd1;
        dst_q <= dst_q + 16'd1;
        len_q <= len_q - 16'd1;
      end

      if (bus.cfg_sel && !bus.cfg_we) cfg_dout_q <= rd_dat;
    end
  end

  assign bus.hold       = hold;
  assign bus.dma_active = active;
  assign bus.dma_we     = we;
  assign bus.dma_addr   = addr;
  assign bus.dma_dout   = dout_q;
  assign bus.cfg_dout   = cfg_dout_q;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_dma16.sv
// Bench for dma16: directed and random transfers against a sequential word-copy model over a 64K-word memory.
module tb_dma16;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dma16_if bus();
  dma16 dut (.clk(clk), .reset_n(reset_n), .bus(bus));

`ifdef DMA_FILL_EN
  localparam bit FILL_BUILD = 1'b1;
`else
  localparam bit FILL_BUILD = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  int hold_cnt, active_cnt, first_act;
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory, one cycle read latency.
  always @(posedge clk) begin
    if (bus.dma_active && bus.dma_we) mem[bus.dma_addr] <= bus.dma_dout;
    bus.dma_din <= mem[bus.dma_addr];
  end

  always @(negedge clk) begin
    if (bus.hold) hold_cnt++;
    if (bus.dma_active) begin
      active_cnt++;
      if (first_act < 0) first_act = cyc;
    end
    if (bus.dma_we) begin
      wr_addr.push_back(bus.dma_addr);
      wr_data.push_back(bus.dma_dout);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    bus.cfg_sel  = 1'b1;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_din  = d;
    @(negedge clk);
    bus.cfg_sel = 1'b0;
    bus.cfg_we  = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [15:0] d);
    bus.cfg_sel  = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = a;
    @(negedge clk);
    bus.cfg_sel = 1'b0;
    d = bus.cfg_dout;
  endtask

  task automatic do_xfer(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                         input int nb, input bit fill_req);
    bit fill;
    int per, n, k, t;
    logic [15:0] ea[$];
    logic [15:0] ed[$];
    logic [15:0] s_a, d_a, d, r, e;
    fill = fill_req & FILL_BUILD;
    per  = fill ? 1 : 3;
    n    = int'(len);
    for (int i = 0; i < n; i++) begin
      s_a = src + 16'(i);
      d_a = dst + 16'(i);
      d   = fill ? src : ref_mem[s_a];
      ref_mem[d_a] = d;
      ea.push_back(d_a);
      ed.push_back(d);
    end
    cfg_write(2'd0, src);
    cfg_write(2'd1, dst);
    cfg_write(2'd2, len);
    bus.busy   = 1'b1;
    hold_cnt   = 0;
    active_cnt = 0;
    first_act  = -1;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    cfg_write(2'd3, fill_req ? 16'h0003 : 16'h0001);
    check("hold_on_start", 32'(bus.hold), 1);
    for (int i = 0; i < nb; i++) begin
      check("no_active_while_busy", 32'(bus.dma_active), 0);
      if (i == 0) cfg_write(2'd1, 16'hDEAD);
      else        @(negedge clk);
    end
    bus.busy = 1'b0;
    k = cyc;
    t = 0;
    while (!bus.irq && t < 3 * n + 20) begin
      @(negedge clk);
      t++;
    end
    check("irq_cycle", 32'(cyc - k), 32'(per * n + 1));
    check("hold_low_at_irq", 32'(bus.hold), 0);
    check("active_low_at_irq", 32'(bus.dma_active), 0);
    @(negedge clk);
    check("irq_one_cycle", 32'(bus.irq), 0);
    check("write_count", 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check("write_addr", 32'(wr_addr[i]), 32'(ea[i]));
      check("write_data", 32'(wr_data[i]), 32'(ed[i]));
      check("write_cycle", 32'(wr_cyc[i] - k), 32'((fill ? 1 : 3) + per * i));
    end
    check("active_cycles", 32'(active_cnt), 32'(per * n));
    check("first_active", 32'(first_act - k), 1);
    check("hold_cycles", 32'(hold_cnt), 32'(nb + 1 + per * n));
    cfg_read(2'd3, r);
    check("status_done", 32'(r), fill ? 32'h6 : 32'h2);
    cfg_read(2'd2, r);
    check("len_final", 32'(r), 0);
    e = fill ? src : src + len;
    cfg_read(2'd0, r);
    check("src_final", 32'(r), 32'(e));
    e = dst + len;
    cfg_read(2'd1, r);
    check("dst_final", 32'(r), 32'(e));
  endtask

  initial begin
    logic [15:0] r;
    int nw, t, bad;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    reset_n      = 1'b0;
    bus.cfg_sel  = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = 2'd0;
    bus.cfg_din  = 16'd0;
    bus.busy     = 1'b0;
    hold_cnt     = 0;
    active_cnt   = 0;
    first_act    = -1;
    repeat (3) @(negedge clk);
    check("rst_hold", 32'(bus.hold), 0);
    check("rst_active", 32'(bus.dma_active), 0);
    check("rst_we", 32'(bus.dma_we), 0);
    check("rst_irq", 32'(bus.irq), 0);
    check("rst_cfg_dout", 32'(bus.cfg_dout), 0);
    check("rst_dma_addr", 32'(bus.dma_addr), 0);
    check("rst_dma_dout", 32'(bus.dma_dout), 0);
    reset_n = 1'b1;
    @(negedge clk);
    cfg_read(2'd3, r);
    check("rst_status", 32'(r), 0);

    do_xfer(16'hF000, 16'h0100, 16'd4, 0, 1'b0);
    do_xfer(16'h2000, 16'h2100, 16'd3, 5, 1'b0);
    do_xfer(16'hFFFE, 16'h0FFF, 16'd3, 1, 1'b0);
    do_xfer(16'h0500, 16'h0502, 16'd6, 2, 1'b0);
    do_xfer(16'hA5A5, 16'h0200, 16'd16, 0, 1'b1);

    // LEN=0 start: immediate DONE and irq, bus never requested.
    cfg_write(2'd3, 16'h0000);
    cfg_read(2'd3, r);
    check("ctrl_clears_done", 32'(r), 0);
    cfg_write(2'd2, 16'd0);
    hold_cnt = 0;
    cfg_write(2'd3, 16'h0001);
    check("len0_irq", 32'(bus.irq), 1);
    check("len0_hold", 32'(bus.hold), 0);
    @(negedge clk);
    check("len0_irq_pulse", 32'(bus.irq), 0);
    cfg_read(2'd3, r);
    check("len0_status", 32'(r), 32'h2);
    check("len0_hold_never", 32'(hold_cnt), 0);

    // Reset during the third WRITE of an 8-word copy: two words land in memory.
    for (int i = 0; i < 2; i++) ref_mem[16'h3100 + 16'(i)] = ref_mem[16'h3000 + 16'(i)];
    cfg_write(2'd0, 16'h3000);
    cfg_write(2'd1, 16'h3100);
    cfg_write(2'd2, 16'd8);
    bus.busy = 1'b0;
    cfg_write(2'd3, 16'h0001);
    nw = 0;
    t  = 0;
    while (nw < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (bus.dma_we) nw++;
    end
    check("third_write_seen", 32'(nw), 3);
    reset_n = 1'b0;
    #1;
    check("arst_hold", 32'(bus.hold), 0);
    check("arst_active", 32'(bus.dma_active), 0);
    check("arst_we", 32'(bus.dma_we), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cfg_read(2'(i), r);
      check("arst_reg", 32'(r), 0);
    end

    repeat (10) begin
      do_xfer(16'($urandom), 16'($urandom), 16'($urandom_range(1, 12)),
              int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", 32'(bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
